// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the ASIP16 memory port arbiter.
// Default widths, starve counter width and read-owner encoding.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 9;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive denied fetch cycles.
// sat flags that fetch must win the next arbitration.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt;

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter in front of the unified 512x16 memory.
// Combinational grant and port mux; registered read owner and strobes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  owner_t rd_owner;
  owner_t own_nxt;
  logic   starved;

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (if_req & ~if_gnt),
    .clr (if_gnt | ~if_req),
    .sat (starved)
  );

  always_comb begin
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    own_nxt  = OWN_NONE;
    if (!rst) begin
      if (if_req && (!ls_req || starved)) begin
        if_gnt = 1'b1;
      end else if (ls_req) begin
        ls_gnt = 1'b1;
      end
    end
    unique case (1'b1)
      if_gnt: begin
        mem_addr = if_addr;
        own_nxt  = OWN_IF;
      end
      ls_gnt: begin
        mem_we   = ls_we;
        mem_addr = ls_addr;
        mem_din  = ls_we ? ls_wdata : '0;
        own_nxt  = ls_we ? OWN_NONE : OWN_LS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= own_nxt;
    end
  end

  assign if_rvalid = (rd_owner == OWN_IF);
  assign ls_rvalid = (rd_owner == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_dout : '0;
  assign ls_rdata  = ls_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 512x16 memory.
// Inputs change on the falling edge; outputs are sampled away from rising edges.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [8:0]  if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [8:0]  ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [15:0] ls_rdata;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [512];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  mem_port_arbiter #(.AW(9), .DW(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  task automatic idle();
    @(negedge clk);
    if_req = 0; ls_req = 0; ls_we = 0;
  endtask

  task automatic store(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    if_req = 0; ls_req = 1; ls_we = 1; ls_addr = a; ls_wdata = d;
  endtask

  task automatic test_reset();
    if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 9'h55; ls_wdata = 16'hFFFF;
    if_addr = 9'h33;
    @(negedge clk); #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rst_if_gnt got %b exp 0", if_gnt); end
    checks++; if (ls_gnt !== 1'b0) begin errors++; $display("FAIL rst_ls_gnt got %b exp 0", ls_gnt); end
    checks++; if ({mem_we, mem_addr, mem_din} !== 26'd0) begin errors++; $display("FAIL rst_mem got %b/%h/%h exp 0", mem_we, mem_addr, mem_din); end
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {if_rvalid, ls_rvalid}); end
    checks++; if ({if_rdata, ls_rdata} !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {if_rdata, ls_rdata}); end
    if_req = 0; ls_req = 0; ls_we = 0;
    rst = 0;
  endtask

  task automatic test_store_load();
    store(9'd0, 16'hABCD);
    #1;
    checks++; if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL st_gnt got %b exp 10", {ls_gnt, if_gnt}); end
    checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 9'd0, 16'hABCD}) begin errors++; $display("FAIL st_mem got %b/%h/%h exp 1/000/abcd", mem_we, mem_addr, mem_din); end
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL st_no_rvalid got %b exp 0", ls_rvalid); end
    ls_we = 0;
    #1;
    checks++; if ({ls_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 9'd0}) begin errors++; $display("FAIL ld_gnt got %b/%b/%h exp 1/0/000", ls_gnt, mem_we, mem_addr); end
    @(negedge clk);
    ls_req = 0;
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 16'hABCD) begin errors++; $display("FAIL ld_data got %b/%h exp 1/abcd", ls_rvalid, ls_rdata); end
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 16'h0) begin errors++; $display("FAIL ld_if_quiet got %b/%h exp 0/0000", if_rvalid, if_rdata); end
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL ld_strobe_once got %b exp 0", ls_rvalid); end
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 10; i++) store(9'(i), 16'(i));
    idle();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'(i - 1) || ls_rdata !== 16'h0) begin
          errors++; $display("FAIL fetch_data[%0d] got %b/%h exp 1/%h", i - 1, if_rvalid, if_rdata, 16'(i - 1));
        end
      end
      if (i < 10) begin
        if_req = 1; if_addr = 9'(i);
        #1;
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 9'(i)) begin errors++; $display("FAIL fetch_gnt[%0d] got %b/%h exp 1/%h", i, if_gnt, mem_addr, 9'(i)); end
      end else begin
        if_req = 0;
      end
    end
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_end got %b exp 0", if_rvalid); end
  endtask

  task automatic test_starve();
    logic prev_if;
    logic exp_if;
    idle();
    prev_if = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (if_rvalid !== prev_if || ls_rvalid !== !prev_if ||
            (prev_if ? if_rdata : ls_rdata) !== (prev_if ? 16'd7 : 16'd5)) begin
          errors++; $display("FAIL starve_rsp[%0d] got %b%b/%h/%h exp if=%b", k, if_rvalid, ls_rvalid, if_rdata, ls_rdata, prev_if);
        end
      end
      if (k < 10) begin
        if_req = 1; if_addr = 9'd7; ls_req = 1; ls_we = 0; ls_addr = 9'd5;
        exp_if = (k % 5 == 4);
        #1;
        checks++;
        if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
          errors++; $display("FAIL starve_gnt[%0d] got %b%b exp %b%b", k, if_gnt, ls_gnt, exp_if, !exp_if);
        end
        prev_if = exp_if;
      end else begin
        if_req = 0; ls_req = 0;
      end
    end
  endtask

  task automatic test_top_addr();
    store(9'd511, 16'h1234);
    @(negedge clk);
    ls_req = 0; if_req = 1; if_addr = 9'd511;
    #1;
    checks++; if ({if_gnt, mem_we, mem_addr, mem_din} !== {1'b1, 1'b0, 9'd511, 16'h0}) begin
      errors++; $display("FAIL top_fetch_port got %b/%b/%h/%h exp 1/0/1ff/0000", if_gnt, mem_we, mem_addr, mem_din);
    end
    @(negedge clk);
    if_req = 0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234 || ls_rvalid !== 1'b0) begin
      errors++; $display("FAIL top_fetch_data got %b/%h/%b exp 1/1234/0", if_rvalid, if_rdata, ls_rvalid);
    end
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    ls_req = 1; ls_we = 0; ls_addr = 9'd3; if_req = 1; if_addr = 9'd4;
    #1;
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rp_gnt got %b exp 1", ls_gnt); end
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++; if ({if_gnt, ls_gnt, ls_rvalid, if_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL rp_in_rst got %b exp 0000", {if_gnt, ls_gnt, ls_rvalid, if_rvalid});
    end
    checks++; if ({mem_we, mem_addr, mem_din, ls_rdata, if_rdata} !== 58'd0) begin
      errors++; $display("FAIL rp_in_rst_data got %b/%h/%h/%h/%h exp 0", mem_we, mem_addr, mem_din, ls_rdata, if_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    ls_req = 0; if_req = 0;
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        errors++; $display("FAIL rp_after[%0d] got %b%b exp 00", k, ls_rvalid, if_rvalid);
      end
    end
  endtask

  task automatic test_random();
    int cnt;
    logic exp_if, exp_ls;
    idle();
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if_req = 1'($urandom_range(0, 1));
      ls_req = 1'($urandom_range(0, 1));
      ls_we = 1'($urandom_range(0, 1));
      if_addr = 9'($urandom);
      ls_addr = 9'($urandom);
      ls_wdata = 16'($urandom);
      exp_if = if_req && (!ls_req || cnt == 4);
      exp_ls = ls_req && !exp_if;
      #1;
      checks++;
      if (if_gnt !== exp_if || ls_gnt !== exp_ls) begin
        errors++; $display("FAIL rand_gnt[%0d] got %b%b exp %b%b cnt=%0d", k, if_gnt, ls_gnt, exp_if, exp_ls, cnt);
      end
      if (if_req && !exp_if) cnt = (cnt < 4) ? cnt + 1 : 4;
      else cnt = 0;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_store_load();
    test_fetch_stream();
    test_starve();
    test_top_addr();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
